// File: rtl/psram_async_ctrl.sv
// psram_async_ctrl: async-mode 16-bit PSRAM controller, one access at a time.
// Optional macro PSRAM_CTRL_WR_HOLD_EN adds a data-hold cycle after writes.
module psram_async_ctrl #(
  parameter int ADDR_W     = 23,
  parameter int READ_WAIT  = 6,
  parameter int WRITE_WAIT = 6,
  parameter int RECOVERY   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic [22:0]       MemAdr,
  inout  wire  [15:0]       MemDB,
  output logic              RamAdv,
  output logic              RamClk,
  output logic              RamCS,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamLB,
  output logic              RamUB
);

  localparam int MAX_RW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int MAX_W  = (MAX_RW > RECOVERY) ? MAX_RW : RECOVERY;
  localparam int CW     = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
`ifdef PSRAM_CTRL_WR_HOLD_EN
    S_HOLD,
`endif
    S_RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic [22:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        drive;
  logic        active;
  logic        lanes_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          adr_d   = 23'(req_addr);
          wdata_d = req_wdata;
          be_d    = req_be;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = we_q ? CW'(WRITE_WAIT) : CW'(READ_WAIT);
      end
      S_ACCESS: begin
        if (cnt_q == CW'(1)) begin
          if (!we_q) rdata_d = MemDB;
          cnt_d   = CW'(RECOVERY);
          state_d = S_RECOVER;
`ifdef PSRAM_CTRL_WR_HOLD_EN
          if (we_q) state_d = S_HOLD;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef PSRAM_CTRL_WR_HOLD_EN
      S_HOLD: begin
        cnt_d   = CW'(RECOVERY);
        state_d = S_RECOVER;
      end
`endif
      S_RECOVER: begin
        if (cnt_q == CW'(1)) state_d = S_IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RECOVER) && (state_q != S_RECOVER);
  end

  // Pin levels decode straight from state so an async reset idles them at once.
  always_comb begin
    active   = 1'b0;
    lanes_on = 1'b0;
    drive    = 1'b0;
    MemOE    = 1'b1;
    MemWR    = 1'b1;
    unique case (state_q)
      S_SETUP: begin
        active = 1'b1;
        drive  = we_q;
      end
      S_ACCESS: begin
        active   = 1'b1;
        lanes_on = 1'b1;
        drive    = we_q;
        MemOE    = we_q;
        MemWR    = !we_q;
      end
`ifdef PSRAM_CTRL_WR_HOLD_EN
      S_HOLD: begin
        active   = 1'b1;
        lanes_on = 1'b1;
        drive    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign RamCS     = !active;
  assign RamAdv    = !active;
  assign RamLB     = !(lanes_on && be_q[0]);
  assign RamUB     = !(lanes_on && be_q[1]);
  assign RamClk    = 1'b0;
  assign MemDB     = drive ? wdata_q : 16'hzzzz;
  assign MemAdr    = adr_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_psram_async_ctrl.sv
// tb_psram_async_ctrl: directed checks on a default and a swept instance.
module tb_psram_async_ctrl;

`ifdef PSRAM_CTRL_WR_HOLD_EN
  localparam int HX = 1;
`else
  localparam int HX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [22:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = 2'b11;
  logic        sel = 1'b0;
  logic [15:0] rd_val = 16'hBEEF;
  int          n_tests = 0;
  int          n_fail = 0;
  int          ovl = 0;

  always #5 clk = ~clk;

  logic        rdy0, rsp0, adv0, rclk0, cs0, oe0, wr0, lb0, ub0;
  logic [15:0] rdata0;
  logic [22:0] adr0;
  wire  [15:0] db0;
  logic        rdy1, rsp1, adv1, rclk1, cs1, oe1, wr1, lb1, ub1;
  logic [15:0] rdata1;
  logic [22:0] adr1;
  wire  [15:0] db1;

  assign db0 = (!oe0 && !cs0) ? rd_val : 16'hzzzz;
  assign db1 = (!oe1 && !cs1) ? rd_val : 16'hzzzz;

  psram_async_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel),
    .req_ready(rdy0), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp0),
    .rsp_rdata(rdata0), .MemAdr(adr0), .MemDB(db0), .RamAdv(adv0),
    .RamClk(rclk0), .RamCS(cs0), .MemOE(oe0), .MemWR(wr0),
    .RamLB(lb0), .RamUB(ub0)
  );

  psram_async_ctrl #(
    .ADDR_W(4), .READ_WAIT(1), .WRITE_WAIT(3), .RECOVERY(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel),
    .req_ready(rdy1), .req_we(req_we), .req_addr(req_addr[3:0]),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp1),
    .rsp_rdata(rdata1), .MemAdr(adr1), .MemDB(db1), .RamAdv(adv1),
    .RamClk(rclk1), .RamCS(cs1), .MemOE(oe1), .MemWR(wr1),
    .RamLB(lb1), .RamUB(ub1)
  );

  wire        m_rdy   = sel ? rdy1 : rdy0;
  wire        m_rsp   = sel ? rsp1 : rsp0;
  wire        m_cs    = sel ? cs1 : cs0;
  wire        m_oe    = sel ? oe1 : oe0;
  wire        m_wr    = sel ? wr1 : wr0;
  wire        m_lb    = sel ? lb1 : lb0;
  wire        m_ub    = sel ? ub1 : ub0;
  wire [15:0] m_rdata = sel ? rdata1 : rdata0;
  wire [22:0] m_adr   = sel ? adr1 : adr0;
  wire [15:0] m_db    = sel ? db1 : db0;

  always @(negedge clk) begin
    if ((!oe0 && !wr0) || (!oe1 && !wr1)) ovl <= ovl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int act_n, rsp_at, rsp_n, rdy_at, drv_n, lane_bad;
  logic [15:0] rsp_data;
  logic [22:0] adr_s;

  task automatic wait_rdy(output int n);
    n = 0;
    while (!m_rdy && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) chk("ready_timeout", 0, 1);
  endtask

  task automatic run(input logic we, input logic [22:0] a,
                     input logic [15:0] d, input logic [1:0] be);
    int n;
    req_we = we; req_addr = a; req_wdata = d; req_be = be;
    req_valid = 1'b1;
    wait_rdy(n);
    @(posedge clk); #1;
    req_valid = 1'b0;
    act_n = 0; rsp_at = -1; rsp_n = 0; rdy_at = -1;
    drv_n = 0; lane_bad = 0; rsp_data = '0;
    adr_s = m_adr;
    for (int j = 0; j < 30 && rdy_at < 0; j++) begin
      if ((we && !m_wr) || (!we && !m_oe)) begin
        act_n++;
        if (m_lb !== !be[0] || m_ub !== !be[1]) lane_bad++;
      end
      if (we && m_db === d) drv_n++;
      if (m_rsp) begin
        rsp_n++;
        if (rsp_at < 0) begin
          rsp_at = j; rsp_data = m_rdata;
        end
      end
      if (m_rdy) rdy_at = j;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  int n, per;
  logic prev_we;

  initial begin
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rdy0, 0);
    chk("rst_ctrl", {cs0, oe0, wr0, lb0, ub0, adv0, rclk0}, 7'b1111110);
    chk("rst_rsp", {rsp0, rdata0}, 17'h0);
    chk("rst_adr", adr0, 0);
    chk("rst_db_rel", (db0 !== 16'h1234), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", rdy0, 1);
    chk("rel_no_acc", cs0, 1);
    @(posedge clk); #1;
    chk("rel_acc", cs0, 0);
    req_valid = 1'b0;
    wait_rdy(n);

    run(1'b0, 23'h000005, 16'h0, 2'b11);
    chk("rd_oe_cycles", act_n, 6);
    chk("rd_rsp_at", rsp_at, 7);
    chk("rd_rsp_once", rsp_n, 1);
    chk("rd_data", rsp_data, 16'hBEEF);
    chk("rd_adr", adr_s, 23'h000005);
    chk("rd_lanes", lane_bad, 0);
    chk("rd_ready_at", rdy_at, 8);

    run(1'b1, 23'h000123, 16'h1234, 2'b10);
    chk("wr_wr_cycles", act_n, 6);
    chk("wr_lanes", lane_bad, 0);
    chk("wr_drive", drv_n, 7 + HX);
    chk("wr_rsp_at", rsp_at, 7 + HX);
    chk("wr_rdata_kept", rsp_data, 16'hBEEF);
    chk("wr_ready_at", rdy_at, 8 + HX);
    chk("wr_db_rel", (db0 !== 16'h1234), 1);

    run(1'b0, 23'h000007, 16'h0, 2'b00);
    chk("be0_oe_cycles", act_n, 6);
    chk("be0_lanes", lane_bad, 0);
    chk("be0_rsp", rsp_n, 1);

    req_valid = 1'b1; req_we = 1'b0; req_be = 2'b11;
    req_wdata = 16'hA55A; req_addr = 23'h10;
    wait_rdy(n);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      prev_we = req_we;
      req_we = !req_we;
      wait_rdy(n);
      @(posedge clk); #1;
      per = n + 1;
      chk(prev_we ? "b2b_wr_period" : "b2b_rd_period", per,
          prev_we ? 9 + HX : 9);
    end
    req_valid = 1'b0;
    wait_rdy(n);
    chk("b2b_no_overlap", ovl, 0);

    sel = 1'b1;
    wait_rdy(n);
    run(1'b0, 23'h00000F, 16'h0, 2'b11);
    chk("sw_rd_cycles", act_n, 1);
    chk("sw_rd_rsp_at", rsp_at, 2);
    chk("sw_rd_ready_at", rdy_at, 4);
    chk("sw_adr", adr_s, 23'h00000F);
    chk("sw_rd_data", rsp_data, 16'hBEEF);
    run(1'b1, 23'h000003, 16'h00C3, 2'b01);
    chk("sw_wr_cycles", act_n, 3);
    chk("sw_wr_lanes", lane_bad, 0);
    chk("sw_wr_rsp_at", rsp_at, 4 + HX);
    chk("sw_wr_ready_at", rdy_at, 6 + HX);
    sel = 1'b0;

    req_we = 1'b1; req_addr = 23'h40; req_wdata = 16'h1234;
    req_be = 2'b11; req_valid = 1'b1;
    wait_rdy(n);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mw_wr_low", wr0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mw_wr_idle", wr0, 1);
    chk("mw_cs_idle", cs0, 1);
    chk("mw_db_rel", (db0 !== 16'h1234), 1);
    rsp_n = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp0) rsp_n++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (rsp0) rsp_n++;
    end
    chk("mw_no_rsp", rsp_n, 0);
    rd_val = 16'h5A5A;
    run(1'b0, 23'h000009, 16'h0, 2'b11);
    chk("mw_next_rd", rsp_data, 16'h5A5A);
    chk("mw_next_rsp_at", rsp_at, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=done", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/psram_async_ctrl.md
# psram_async_ctrl

Parametrised asynchronous-mode controller for the board's 16-bit cellular RAM (PSRAM). It sits between synthesizer logic (sample/wavetable storage) and the external memory pins. It accepts one read or write request at a time over a valid/ready handshake, sequences CS/OE/WR/byte-lane strobes with configurable wait and recovery counts, and returns read data or write completion on a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 23: request address width in 16-bit words; legal range 1..23.
- READ_WAIT, 6: cycles OE/CS held low per read; minimum 1.
- WRITE_WAIT, 6: cycles WR/CS held low per write; minimum 1.
- RECOVERY, 1: idle cycles (CS high) after each access; minimum 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; registered.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  16  write data.
- req_be  in  2  byte enables; bit0 = low byte, bit1 = high byte.
- rsp_valid  out  1  one-cycle pulse at access completion (read or write).
- rsp_rdata  out  16  read data; updated only by reads.
- MemAdr  out  23  memory address, req_addr zero-extended.
- MemDB  inout  16  memory data bus; tri-stated unless driving a write.
- RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB  out  1 each  memory control pins; all active-low except RamClk.

## Operation
- States: IDLE, SETUP, ACCESS, RECOVER. Add HOLD when PSRAM_CTRL_WR_HOLD_EN is defined.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/addr/wdata/be, clear req_ready, go to SETUP.
- SETUP, 1 cycle:
  - MemAdr driven; RamCS=0, RamAdv=0, MemOE=1, MemWR=1, lanes high.
  - For a write, MemDB is driven with the latched wdata.
- ACCESS:
  - A down-counter is loaded with READ_WAIT or WRITE_WAIT; the state exits when the counter reaches 1.
  - Read: RamCS=0, RamAdv=0, MemOE=0, RamLB=~be[0], RamUB=~be[1].
  - Write: RamCS=0, RamAdv=0, MemWR=0, same lane mapping, MemDB driven.
  - Read data: MemDB is sampled into rsp_rdata on the edge that ends the last ACCESS cycle.
- HOLD: write only, when enabled. See Configuration.
- RECOVER, RECOVERY cycles:
  - All controls idle; MemDB released.
  - rsp_valid high for exactly the first RECOVER cycle.
  - Then IDLE.
- Idle control levels: RamCS=MemOE=MemWR=RamLB=RamUB=RamAdv=1, RamClk=0. RamClk is always 0 (asynchronous mode).
- Counter width is clog2(max(READ_WAIT,WRITE_WAIT,RECOVERY)+1). Address is zero-extended to 23 bits.
- req_be=0 still runs a full cycle with both lanes high; rsp_valid still pulses.
- A request presented while req_ready=0 is ignored, not queued.
- MemAdr holds its last value outside accesses.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, MemAdr=0.
  - All controls at idle levels; MemDB tri-stated; state=IDLE.
  - req_ready rises on the first clk edge after rst_n deasserts.
- Reset asserted mid-access: controls go idle and MemDB releases immediately (asynchronous). No rsp_valid is issued for the aborted access.
- Read, with accept edge E0:
  - SETUP occupies cycle E0..E1.
  - ACCESS occupies E1..E1+READ_WAIT.
  - rsp_valid is high in the cycle after E1+READ_WAIT, i.e. READ_WAIT+1 edges after E0.
- Write: same as read using WRITE_WAIT, plus 1 cycle if HOLD is compiled in.
- Throughput: req_ready returns 1 at edge E0+1+WAIT+RECOVERY (+1 for a write with HOLD). Default read period is 9 cycles including the accept cycle.
- Bus turnaround: MemDB is never driven while MemOE=0.

## Configuration
- PSRAM_CTRL_WR_HOLD_EN
  - Defined: after write ACCESS, one HOLD cycle with MemWR=1 and RamCS=0, lanes still asserted, MemDB still driven. This gives data hold after the WR rising edge; RECOVER follows.
  - Undefined: no HOLD state; write ACCESS goes directly to RECOVER and MemDB releases on the same edge MemWR rises.

## Test plan
- Reset: hold rst_n=0 with req_valid=1 → all controls idle, MemDB=Z, req_ready=0; one edge after release req_ready=1, no access started until then.
- Read (defaults): read addr 0x000005, be=2'b11, memory model returns 0xBEEF → MemOE=0 for exactly 6 cycles; rsp_rdata=0xBEEF with rsp_valid 7 edges after accept; MemAdr=0x000005.
- Write lane masking: write 0x1234 with be=2'b10 → RamUB=0, RamLB=1 during 6 MemWR-low cycles; MemDB=0x1234 from SETUP through the last write cycle; plus one HOLD cycle when the macro is on.
- Back-to-back: keep req_valid=1 with alternating read/write → accepts exactly every 9 cycles (10 for writes with HOLD); MemOE and MemWR never low simultaneously; no drive while MemOE=0.
- Parameter sweep: READ_WAIT=1, WRITE_WAIT=3, RECOVERY=2, ADDR_W=4 → ACCESS lengths 1 and 3 with a 2-cycle RECOVER; req_addr=4'hF gives MemAdr=23'h00000F.
- Reset mid-write: drop rst_n during ACCESS cycle 3 → MemWR/RamCS return to 1 and MemDB=Z without a clock edge; no rsp_valid; next read completes normally.
